// File: rtl/demux_steer_1x2_if.sv
// -----------------------------------------------------------------------------
// demux_steer_1x2_if
// Bundles the input stream and the two demuxed output streams of the
// demux_steer_1x2 steering stage.
//
//   in_valid / in_ready / in_data / in_dest : producer -> steering stage
//   y0_valid / y0_ready / y0_data           : steering stage -> consumer 0
//   y1_valid / y1_ready / y1_data           : steering stage -> consumer 1
//
// Modports:
//   master : producer + consumers side (drives valid/data/dest and yN_ready)
//   slave  : steering stage side (drives in_ready and the yN outputs)
// -----------------------------------------------------------------------------
interface demux_steer_1x2_if #(
  parameter int DW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_dest;

  logic          y0_valid;
  logic          y0_ready;
  logic [DW-1:0] y0_data;

  logic          y1_valid;
  logic          y1_ready;
  logic [DW-1:0] y1_data;

  modport master (
    output in_valid, in_data, in_dest, y0_ready, y1_ready,
    input  in_ready, y0_valid, y0_data, y1_valid, y1_data
  );

  modport slave (
    input  in_valid, in_data, in_dest, y0_ready, y1_ready,
    output in_ready, y0_valid, y0_data, y1_valid, y1_data
  );
endinterface

// File: rtl/demux_steer_1x2.sv
// -----------------------------------------------------------------------------
// demux_steer_1x2
// Buffered 1-to-2 stream steering stage. Each accepted input word is routed
// either by its destination bit or by a round-robin pointer into one of two
// small output FIFOs, so a stalled consumer never causes data loss.
//
// Ports:
//   i_clk      : single clock, rising edge
//   i_rst      : synchronous active-high reset
//   bus        : demux_steer_1x2_if.slave (input stream + two output streams)
//   i_rr_mode  : 1 = round-robin steering (in_dest ignored)
//   o_sel_q    : destination of the most recently accepted word
//   o_cnt0/1   : accepted-word counters toward y0/y1 (saturating)
//
// Parameters: DW data width, DEPTH entries per FIFO (power of 2, >=2),
//             CW counter width.
// Build option: DEMUX_STEER_CNT_EN enables the counters; otherwise they
//               read constant zero.
// -----------------------------------------------------------------------------
module demux_steer_1x2 #(
  parameter int DW    = 8,
  parameter int DEPTH = 2,
  parameter int CW    = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  demux_steer_1x2_if.slave     bus,
  input  logic                 i_rr_mode,
  output logic                 o_sel_q,
  output logic [CW-1:0]        o_cnt0,
  output logic [CW-1:0]        o_cnt1
);

  localparam int AW = $clog2(DEPTH);

  // FIFO storage and pointers; the extra pointer MSB distinguishes full/empty
  logic [DW-1:0] r_mem0 [DEPTH];
  logic [DW-1:0] r_mem1 [DEPTH];
  logic [AW:0]   r_wr0;
  logic [AW:0]   r_rd0;
  logic [AW:0]   r_wr1;
  logic [AW:0]   r_rd1;

  logic          r_rr_ptr;
  logic          r_sel_q;

  logic          w_empty0;
  logic          w_empty1;
  logic          w_full0;
  logic          w_full1;
  logic          w_tgt;
  logic          w_in_ready;
  logic          w_accept;
  logic          w_push0;
  logic          w_push1;
  logic          w_pop0;
  logic          w_pop1;

  // Occupancy decode from the registered pointers
  always_comb begin
    w_empty0 = (r_wr0 == r_rd0);
    w_empty1 = (r_wr1 == r_rd1);
    w_full0  = (r_wr0[AW] != r_rd0[AW]) && (r_wr0[AW-1:0] == r_rd0[AW-1:0]);
    w_full1  = (r_wr1[AW] != r_rd1[AW]) && (r_wr1[AW-1:0] == r_rd1[AW-1:0]);
  end

  // Target selection and handshake; ready uses registered full only, so a pop
  // in the same cycle never frees a slot for the incoming word
  always_comb begin
    w_tgt = i_rr_mode ? r_rr_ptr : bus.in_dest;
    if (w_tgt) begin
      w_in_ready = !w_full1;
    end else begin
      w_in_ready = !w_full0;
    end
    w_accept = bus.in_valid & w_in_ready;
    w_push0  = w_accept & !w_tgt;
    w_push1  = w_accept &  w_tgt;
    w_pop0   = !w_empty0 & bus.y0_ready;
    w_pop1   = !w_empty1 & bus.y1_ready;
  end

  assign bus.in_ready = w_in_ready;
  assign bus.y0_valid = !w_empty0;
  assign bus.y1_valid = !w_empty1;
  assign bus.y0_data  = r_mem0[r_rd0[AW-1:0]];
  assign bus.y1_data  = r_mem1[r_rd1[AW-1:0]];
  assign o_sel_q      = r_sel_q;

  // FIFO pointer update; push and pop are independent so a simultaneous
  // push/pop on a non-full FIFO leaves occupancy unchanged
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr0 <= {(AW+1){1'b0}};
      r_rd0 <= {(AW+1){1'b0}};
      r_wr1 <= {(AW+1){1'b0}};
      r_rd1 <= {(AW+1){1'b0}};
    end else begin
      if (w_push0) r_wr0 <= r_wr0 + {{AW{1'b0}}, 1'b1};
      if (w_pop0)  r_rd0 <= r_rd0 + {{AW{1'b0}}, 1'b1};
      if (w_push1) r_wr1 <= r_wr1 + {{AW{1'b0}}, 1'b1};
      if (w_pop1)  r_rd1 <= r_rd1 + {{AW{1'b0}}, 1'b1};
    end
  end

  // FIFO storage; cleared on reset so the head words read zero afterwards
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem0[i] <= {DW{1'b0}};
        r_mem1[i] <= {DW{1'b0}};
      end
    end else begin
      if (w_push0) r_mem0[r_wr0[AW-1:0]] <= bus.in_data;
      if (w_push1) r_mem1[r_wr1[AW-1:0]] <= bus.in_data;
    end
  end

  // Routing state: last destination and round-robin pointer (toggles only on
  // accepts made while round-robin is active)
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sel_q  <= 1'b0;
      r_rr_ptr <= 1'b0;
    end else if (w_accept) begin
      r_sel_q <= w_tgt;
      if (i_rr_mode) r_rr_ptr <= ~r_rr_ptr;
    end
  end

`ifdef DEMUX_STEER_CNT_EN
  logic [CW-1:0] r_cnt0;
  logic [CW-1:0] r_cnt1;

  // Saturating accepted-word counters per destination
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt0 <= {CW{1'b0}};
      r_cnt1 <= {CW{1'b0}};
    end else begin
      if (w_push0 && (r_cnt0 != {CW{1'b1}})) r_cnt0 <= r_cnt0 + {{(CW-1){1'b0}}, 1'b1};
      if (w_push1 && (r_cnt1 != {CW{1'b1}})) r_cnt1 <= r_cnt1 + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  assign o_cnt0 = r_cnt0;
  assign o_cnt1 = r_cnt1;
`else
  assign o_cnt0 = {CW{1'b0}};
  assign o_cnt1 = {CW{1'b0}};
`endif

endmodule

// File: doc/demux_steer_1x2.md
# demux_steer_1x2

Buffered 1-to-2 stream steering stage that feeds the 1x2 demultiplexer path. It accepts a valid/ready input stream and routes each word to one of two output streams, by per-word destination bit or by round-robin. Each output has its own small FIFO, so one stalled consumer does not drop data. It sits between a single producer and the two demuxed consumers and exposes the routing decision as `sel_q`.

## Interface
- `DW`, 8, data width in bits (>=1)
- `DEPTH`, 2, entries per output FIFO (power of 2, >=2)
- `CW`, 16, width of per-output accepted-word counters

- `clk`  input  1  single clock, all logic on rising edge
- `rst`  input  1  synchronous, active-high reset
- `in_valid`  input  1  input word present
- `in_ready`  output  1  input word will be accepted this cycle
- `in_data`  input  DW  input payload
- `in_dest`  input  1  destination (0 -> y0, 1 -> y1); used only when `rr_mode`=0
- `rr_mode`  input  1  1 = round-robin steering, `in_dest` ignored
- `y0_valid` / `y1_valid`  output  1  output FIFO non-empty
- `y0_ready` / `y1_ready`  input  1  consumer accepts head word
- `y0_data` / `y1_data`  output  DW  head word of the respective FIFO
- `sel_q`  output  1  destination of the most recently accepted word
- `cnt0` / `cnt1`  output  CW  words accepted toward y0 / y1 (see Configuration)

## Operation
- Target: `tgt = rr_mode ? rr_ptr : in_dest`.
- `in_ready = !full[tgt]`. This is combinational from `rr_mode`, `rr_ptr`, `in_dest` and FIFO state. It does not depend on `in_valid`.
- Accept = `in_valid & in_ready`. On accept:
  - push `in_data` into FIFO[`tgt`];
  - `sel_q <= tgt`;
  - if `rr_mode`=1, `rr_ptr <= ~rr_ptr`.
- `rr_ptr` only toggles on accepts made in round-robin mode. It keeps its value across `rr_mode` changes; a change of `rr_mode` takes effect on the next accept.
- Head-of-line blocking: if FIFO[`tgt`] is full, input stalls even when the other FIFO has space. Words are never reordered or dropped.
- Outputs:
  - `yN_valid = !emptyN`;
  - `yN_data` = FIFO head, held stable while `yN_valid & !yN_ready`;
  - pop on `yN_valid & yN_ready`.
- Full FIFO with a pop in the same cycle: no push that cycle (`in_ready` uses registered full only, no pass-through).
- Non-full FIFO with push and pop in the same cycle: both occur, occupancy unchanged.
- FIFO pointers are log2(DEPTH)+1 bits wide. Full and empty are decoded from the MSB difference, so wrap-around is exact.
- Reset, including mid-transfer:
  - both FIFOs emptied (contents discarded);
  - `rr_ptr`=0, `sel_q`=0, `cnt0`=`cnt1`=0;
  - hence `y0_valid`=`y1_valid`=0 and `in_ready`=1 in the cycle after reset is sampled.

## Timing
- Latency: a word accepted at edge k is visible on `yN_valid`/`yN_data` after edge k (registered FIFO, 1 cycle). No combinational in->out path.
- Throughput: 1 word/cycle sustained when the target FIFO is not full.
- `in_ready` may change combinationally with `in_dest` inside a cycle. The producer must hold `in_data`/`in_dest` stable while `in_valid & !in_ready`.
- Output handshake is standard: once `yN_valid`=1 it stays 1 until popped, except on reset.
- Reset values:
  - `in_ready` = 1 (both FIFOs empty, so `tgt` is not full);
  - all other outputs = 0.

## Configuration
- `DEMUX_STEER_CNT_EN` defined:
  - `cnt0`/`cnt1` increment by 1 on each accept toward y0/y1;
  - they saturate at 2^CW-1 (no wrap) and clear on `rst`.
- Not defined: counter logic is omitted and `cnt0`/`cnt1` are tied to 0. All other behaviour is identical.

## Test plan
- Reset: assert `rst` mid-stream with both FIFOs holding 2 words -> next cycle `y0_valid`=`y1_valid`=0, `in_ready`=1, `sel_q`=0, counters 0; no stale data appears after release.
- Dest steering:
  - stimulus: `rr_mode`=0, send 0xA1(dest 0), 0xB2(dest 1), 0xC3(dest 0), all ready=1;
  - response: y0 emits A1, C3; y1 emits B2; each word 1 cycle after accept; `sel_q` sequence 0,1,0.
- Round-robin:
  - stimulus: `rr_mode`=1, 4 words 0x10..0x13, `in_dest` randomized;
  - response: y0 gets 10, 12; y1 gets 11, 13;
  - then set `rr_mode`=0 for one word and back to 1 -> next RR word goes to y0 (`rr_ptr` untouched).
- Backpressure / HOL:
  - stimulus: `y0_ready`=0, DEPTH=2, send 3 words to dest 0;
  - response: `in_ready`=0 on the 3rd word, and a dest-1 word behind it also waits;
  - on `y0_ready`=1 for one cycle, one pop, then 3rd word accepted next cycle; order preserved.
- Full + simultaneous pop:
  - stimulus: FIFO0 full, `y0_ready`=1 and `in_valid` to dest 0 in the same cycle;
  - response: pop occurs, push does not (`in_ready`=0); push accepted the following cycle; pointer wrap over 3×DEPTH words gives correct data.
- Counters (with `DEMUX_STEER_CNT_EN`, CW=4):
  - stimulus: 20 words to y0;
  - response: `cnt0` saturates at 15, `cnt1`=0;
  - without the macro both read 0 throughout.
